spi_sp_ram: RTL

- Single-port synchronous RAM that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid words: bits [9:8] are the command, bits [7:0] are the payload.
- Returns read data to the slave on tx_data/tx_valid. tx_valid is held long enough for the slave to shift out all 8 bits on MISO.
- Keeps separate write-address and read-address pointers, with optional auto-increment.

---
 rtl/spi_ram_pkg.sv | 18 +
 rtl/sp_ram_array.sv | 24 ++
 rtl/spi_sp_ram.sv | 99 +++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command and field definitions for the SPI slave and its RAM.
// The slave and the RAM decode the same 10-bit word layout.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int CMD_MSB = 9;
    localparam int CMD_LSB = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_t;

endpackage

// File: rtl/sp_ram_array.sv
// Plain DEPTH x 8 storage: synchronous write, combinational read.
// No reset; contents are undefined until written.
module sp_ram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/spi_sp_ram.sv
// Single-port RAM behind the SPI slave: decodes 10-bit command words
// and holds read data long enough for one MISO byte.
module spi_sp_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy
);

    localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
    localparam logic [ADDR_SIZE:0] DEPTH_V = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] load_addr;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [CNT_W-1:0]     hold_cnt;
    hold_state_t          state;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 ram_we;
    logic [7:0]           ram_dout;

    function automatic logic [ADDR_SIZE-1:0] bump(
        input logic [ADDR_SIZE-1:0] p
    );
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign cmd       = rx_data[CMD_MSB:CMD_LSB];
    assign load_addr = rx_data[ADDR_SIZE-1:0];
    assign wr_ok     = {1'b0, wr_addr} < DEPTH_V;
    assign rd_ok     = {1'b0, rd_addr} < DEPTH_V;
    assign ram_addr  = (cmd == CMD_WR_DATA) ? wr_addr : rd_addr;
    assign ram_we    = rx_valid && (cmd == CMD_WR_DATA) && wr_ok;
    assign busy      = tx_valid;

    sp_ram_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_SIZE)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (rx_data[7:0]),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            hold_cnt <= '0;
            wr_addr  <= '0;
            rd_addr  <= '0;
        end else begin
            if (state == HOLD) begin
                if (hold_cnt == '0) begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
            // A read here overrides the countdown above, restarting the hold.
            if (rx_valid) begin
                unique case (cmd)
                    CMD_WR_ADDR: wr_addr <= load_addr;
                    CMD_WR_DATA: begin
                        if (AUTO_INC != 0) wr_addr <= bump(wr_addr);
                    end
                    CMD_RD_ADDR: rd_addr <= load_addr;
                    CMD_RD_DATA: begin
                        tx_data  <= rd_ok ? ram_dout : 8'h00;
                        tx_valid <= 1'b1;
                        state    <= HOLD;
                        hold_cnt <= CNT_W'(TX_HOLD - 1);
                        if (AUTO_INC != 0) rd_addr <= bump(rd_addr);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
